// File: rtl/cipher_pkg.sv
// Shared AES widths, round counts and GF(2^8) helpers used by the encrypt/decrypt round logic.
// The S-box is computed as the GF(2^8) inverse followed by the FIPS-197 affine map, so no table is needed.
package cipher_pkg;

  localparam int BLK_S          = 128;
  localparam int ROUND_KEY_BITS = 128;
  localparam int NB             = 4;
  localparam int NR_128         = 10;
  localparam int NR_192         = 12;
  localparam int NR_256         = 14;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0), built from x^2 * x^4 * ... * x^128
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    logic [7:0] b;
    sq  = gf_mul(x, x);
    acc = sq;
    for (int i = 1; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    b = acc;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns (skipped on final), AddRoundKey.
// Byte i of the block sits in bits [8i+7:8i]; byte 4c+r is row r of column c.
module aes_enc_round
  import cipher_pkg::*;
(
  input  logic [BLK_S-1:0]          state_in,
  input  logic [ROUND_KEY_BITS-1:0] round_key,
  input  logic                      final_round,
  output logic [BLK_S-1:0]          state_out
);

  logic [7:0] sb [0:15];
  logic [7:0] sr [0:15];
  logic [7:0] mc [0:15];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(state_in[8*i +: 8]);
    end
    // row r rotates left by r columns
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++) begin
      state_out[8*i +: 8] = (final_round ? sr[i] : mc[i]) ^ round_key[8*i +: 8];
    end
  end

endmodule

// File: rtl/cipher.sv
// Iterative AES encryptor, one round per cycle, round keys read from an external SRAM by round_no.
// Done pulse Nr+2 cycles after the start edge; en ignored while busy; CIPHER_ABORT_EN adds an abort input.
module cipher
  import cipher_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
`ifdef CIPHER_ABORT_EN
  input  logic                      abort,
`endif
  input  logic [NB-1:0]             rounds_total,
  input  logic [BLK_S-1:0]          plaintext,
  input  logic [ROUND_KEY_BITS-1:0] round_key,
  output logic [BLK_S-1:0]          ciphertext,
  output logic [NB-1:0]             round_no,
  output logic                      en_o,
  output logic                      busy
);

  typedef enum logic [2:0] {IDLE, FETCH, INIT, ROUND, DONE} state_e;

  state_e           st, st_d;
  logic [BLK_S-1:0] blk, blk_d;
  logic [NB-1:0]    nr_q, nr_d;
  logic [NB-1:0]    r_q, r_d;
  logic [NB-1:0]    rn_d;
  logic [BLK_S-1:0] ct_d;
  logic             en_o_d;
  logic             busy_d;
  logic [BLK_S-1:0] round_out;
  logic             final_round;
  logic [NB:0]      rn_inc;

  assign final_round = (r_q == nr_q);
  assign rn_inc      = {1'b0, r_q} + {{(NB-1){1'b0}}, 2'b10};

  aes_enc_round u_round (
    .state_in    (blk),
    .round_key   (round_key),
    .final_round (final_round),
    .state_out   (round_out)
  );

  always_comb begin
    st_d   = st;
    blk_d  = blk;
    nr_d   = nr_q;
    r_d    = r_q;
    rn_d   = round_no;
    ct_d   = ciphertext;
    en_o_d = 1'b0;
    busy_d = busy;
    case (st)
      IDLE: begin
        if (en && rounds_total != '0) begin
          blk_d  = plaintext;
          nr_d   = rounds_total;
          rn_d   = '0;
          busy_d = 1'b1;
          st_d   = FETCH;
        end
      end
      FETCH: begin
        rn_d = {{(NB-1){1'b0}}, 1'b1};
        st_d = INIT;
      end
      INIT: begin
        // round_key now carries key[0], requested two edges ago
        blk_d = blk ^ round_key;
        rn_d  = (nr_q < NB'(2)) ? nr_q : NB'(2);
        r_d   = {{(NB-1){1'b0}}, 1'b1};
        st_d  = ROUND;
      end
      ROUND: begin
        blk_d = round_out;
        r_d   = r_q + {{(NB-1){1'b0}}, 1'b1};
        rn_d  = (rn_inc > {1'b0, nr_q}) ? nr_q : rn_inc[NB-1:0];
        if (final_round) begin
          ct_d   = round_out;
          en_o_d = 1'b1;
          st_d   = DONE;
        end
      end
      DONE: begin
        busy_d = 1'b0;
        rn_d   = '0;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
`ifdef CIPHER_ABORT_EN
    if (abort && (st == FETCH || st == INIT || st == ROUND)) begin
      st_d   = IDLE;
      busy_d = 1'b0;
      rn_d   = '0;
      en_o_d = 1'b0;
      ct_d   = ciphertext;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= IDLE;
      blk        <= '0;
      nr_q       <= '0;
      r_q        <= '0;
      round_no   <= '0;
      ciphertext <= '0;
      en_o       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      st         <= st_d;
      blk        <= blk_d;
      nr_q       <= nr_d;
      r_q        <= r_d;
      round_no   <= rn_d;
      ciphertext <= ct_d;
      en_o       <= en_o_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_cipher.sv
// Directed bench for cipher: FIPS-197 vectors for 128/192/256-bit keys, round index trace, busy-ignore,
// mid-operation reset, zero-round start and (with CIPHER_ABORT_EN) abort.
module tb_cipher;
  import cipher_pkg::*;

  localparam logic [127:0] PT     = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CT_128 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] CT_192 = 128'h91710deca070af6ee0df4c86a47ca9dd;
  localparam logic [127:0] CT_256 = 128'h8960494b9049fceabf456751cab7a28e;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
`ifdef CIPHER_ABORT_EN
  logic         abort;
`endif
  logic [3:0]   rounds_total;
  logic [127:0] plaintext;
  logic [127:0] round_key;
  logic [127:0] ciphertext;
  logic [3:0]   round_no;
  logic         en_o;
  logic         busy;

  always #5 clk = ~clk;

  cipher dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
`ifdef CIPHER_ABORT_EN
    .abort        (abort),
`endif
    .rounds_total (rounds_total),
    .plaintext    (plaintext),
    .round_key    (round_key),
    .ciphertext   (ciphertext),
    .round_no     (round_no),
    .en_o         (en_o),
    .busy         (busy)
  );

  logic [127:0] kmem [0:14];

  always @(posedge clk) round_key <= kmem[round_no];

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (tb_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    c = 8'h63;
    for (int i = 0; i < 8; i++) begin
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    end
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
  endfunction

  // FIPS-197 key expansion for the key 00 01 02 ... (4*nk-1)
  task automatic load_keys(input int nk, input int nr);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[7:0], t[31:8]}) ^ {24'h0, rcon};
        rcon = tb_mul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) kmem[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  int           trace_rn [0:31];
  logic         trace_busy [0:31];
  int           lat;
  int           pulses;
  logic [127:0] ct_mid;

  // Starts one block, then observes nr+6 cycles; index k is the state after edge Tk.
  task automatic run(input logic [127:0] pt, input int nr, input int repulse_at);
    @(posedge clk); #1;
    plaintext = pt; rounds_total = 4'(nr); en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; plaintext = ~pt; rounds_total = 4'd3;
    lat = -1; pulses = 0;
    for (int k = 0; k < nr + 6; k++) begin
      if (repulse_at > 0 && k == repulse_at - 1) begin
        en = 1'b1; plaintext = 128'h0123456789abcdef0123456789abcdef; rounds_total = 4'(NR_256);
      end
      if (repulse_at > 0 && k == repulse_at) en = 1'b0;
      @(negedge clk);
      trace_rn[k]   = int'(round_no);
      trace_busy[k] = busy;
      if (k == 5) ct_mid = ciphertext;
      if (en_o) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic count_pulses(input int cycles);
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (en_o) pulses++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_rn;
    reset = 1'b0; en = 1'b0; rounds_total = '0; plaintext = '0;
`ifdef CIPHER_ABORT_EN
    abort = 1'b0;
`endif
    load_keys(4, NR_128);
    #12;
    chk("reset_ct", ciphertext, 128'h0);
    chk("reset_round_no", 128'(round_no), 128'h0);
    chk("reset_en_o", 128'(en_o), 128'h0);
    chk("reset_busy", 128'(busy), 128'h0);
    @(posedge clk); #1 reset = 1'b1;

    run(PT, NR_128, 0);
    chk("aes128_ct", ciphertext, CT_128);
    chk("aes128_latency", 128'(lat), 128'd12);
    chk("aes128_pulses", 128'(pulses), 128'd1);
    for (int k = 0; k < 16; k++) begin
      exp_rn = (k <= 1) ? k : (k <= 12) ? ((k < 10) ? k : 10) : 0;
      chk($sformatf("aes128_round_no[%0d]", k), 128'(trace_rn[k]), 128'(exp_rn));
      chk($sformatf("aes128_busy[%0d]", k), 128'(trace_busy[k]), (k <= 12) ? 128'd1 : 128'd0);
    end

    load_keys(6, NR_192);
    run(PT, NR_192, 0);
    chk("aes192_ct", ciphertext, CT_192);
    chk("aes192_latency", 128'(lat), 128'd14);

    load_keys(8, NR_256);
    run(PT, NR_256, 0);
    chk("aes256_ct", ciphertext, CT_256);
    chk("aes256_latency", 128'(lat), 128'd16);
    chk("aes256_pulses", 128'(pulses), 128'd1);

    load_keys(4, NR_128);
    run(PT, NR_128, 5);
    chk("busy_ignore_ct", ciphertext, CT_128);
    chk("busy_ignore_pulses", 128'(pulses), 128'd1);
    chk("ct_held_mid_op", ct_mid, CT_256);
    run(PT, NR_128, 0);
    chk("restart_ct", ciphertext, CT_128);
    chk("restart_pulses", 128'(pulses), 128'd1);

    @(posedge clk); #1 en = 1'b1; rounds_total = 4'd0; plaintext = PT;
    @(posedge clk); #1 en = 1'b0;
    @(negedge clk);
    chk("zero_rounds_busy", 128'(busy), 128'd0);
    chk("zero_rounds_round_no", 128'(round_no), 128'd0);
    count_pulses(4);
    chk("zero_rounds_busy_later", 128'(busy), 128'd0);
    chk("zero_rounds_pulses", 128'(pulses), 128'd0);

    @(posedge clk); #1 en = 1'b1; rounds_total = 4'(NR_128); plaintext = PT;
    @(posedge clk); #1 en = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midreset_ct", ciphertext, 128'h0);
    chk("midreset_round_no", 128'(round_no), 128'h0);
    chk("midreset_en_o", 128'(en_o), 128'h0);
    chk("midreset_busy", 128'(busy), 128'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    count_pulses(20);
    chk("midreset_pulses", 128'(pulses), 128'd0);
    run(PT, NR_128, 0);
    chk("post_reset_ct", ciphertext, CT_128);

`ifdef CIPHER_ABORT_EN
    @(posedge clk); #1 en = 1'b1; rounds_total = 4'(NR_128); plaintext = ~PT;
    @(posedge clk); #1 en = 1'b0;
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_round_no", 128'(round_no), 128'd0);
    chk("abort_ct_kept", ciphertext, CT_128);
    count_pulses(20);
    chk("abort_pulses", 128'(pulses), 128'd0);
    run(PT, NR_128, 0);
    chk("post_abort_ct", ciphertext, CT_128);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
